// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: streams len operand pairs from two synchronous-read
// memories into one external MAC, drains its pipeline and returns the
// accumulated 16-bit dot product with a one-cycle done pulse.
module mac_dot_sequencer #(
  parameter int AW      = 8,
  parameter int MAC_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   len,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  output logic          busy,
  output logic          done,
  output logic [15:0]   result,
  output logic          rd_en,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  input  logic [15:0]   rdata_a,
  input  logic [15:0]   rdata_b,
  output logic          mac_clr,
  output logic          mac_en,
  output logic [15:0]   mac_a,
  output logic [15:0]   mac_b,
  input  logic [15:0]   mac_acc
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_CAPT  = 3'd4;

  // drain counter only has to hold MAC_LAT-1
  localparam int CW = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT);

  logic [2:0]    state;
  logic [AW:0]   len_q;
  logic [AW:0]   idx;
  logic [AW-1:0] base_a_q;
  logic [AW-1:0] base_b_q;
  logic [CW-1:0] cnt;
  logic          dv;       // read data on rdata_* is valid this cycle
  logic          aborting; // abort only acts outside IDLE

  assign aborting = abort && (state != S_IDLE);
  assign busy     = (state != S_IDLE);

  // Read strobe and wrapping addresses; abort kills the strobe at once
  // so no read is issued for a cancelled job.
  assign rd_en  = (state == S_FETCH) && !aborting;
  assign addr_a = base_a_q + idx[AW-1:0];
  assign addr_b = base_b_q + idx[AW-1:0];

  // Enable covers data cycles plus drain; zeros on the operands during
  // drain flush the MAC pipeline so the final sum lands on mac_acc.
  assign mac_en = (dv || (state == S_DRAIN)) && !aborting;
  assign mac_a  = dv ? rdata_a : 16'h0000;
  assign mac_b  = dv ? rdata_b : 16'h0000;

  // Sequencer state, job latches, counters and registered pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      idx      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      cnt      <= '0;
      dv       <= 1'b0;
      mac_clr  <= 1'b0;
      done     <= 1'b0;
      result   <= 16'h0000;
    end else begin
      mac_clr <= 1'b0;
      done    <= 1'b0;
      dv      <= rd_en;
      if (aborting) begin
        state   <= S_IDLE;
        mac_clr <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (start && !abort) begin
            len_q    <= len;
            base_a_q <= base_a;
            base_b_q <= base_b;
            idx      <= '0;
            mac_clr  <= 1'b1;
            state    <= S_CLEAR;
          end
          S_CLEAR: state <= (len_q != '0) ? S_FETCH : S_CAPT;
          S_FETCH: begin
            if (idx == len_q - 1'b1) begin
              cnt   <= CW'(MAC_LAT - 1);
              state <= S_DRAIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          S_DRAIN: begin
            if (cnt == '0) state <= S_CAPT;
            else           cnt   <= cnt - 1'b1;
          end
          S_CAPT: begin
            result <= mac_acc;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer: operand memories and a 3-stage
// MAC are modelled around the DUT; expected results are hand computed.
module tb_mac_dot_sequencer;

  logic        clk, rst, start, abort;
  logic [8:0]  len;
  logic [7:0]  base_a, base_b, addr_a, addr_b;
  logic        busy, done, rd_en, mac_clr, mac_en;
  logic [15:0] result, rdata_a, rdata_b, mac_a, mac_b, mac_acc;

  mac_dot_sequencer #(.AW(8), .MAC_LAT(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
    .base_a(base_a), .base_b(base_b), .busy(busy), .done(done),
    .result(result), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .mac_clr(mac_clr),
    .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read operand memories
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  always @(posedge clk) begin
    if (rd_en) begin
      rdata_a <= mem_a[addr_a];
      rdata_b <= mem_b[addr_b];
    end
  end

  // MAC: operand reg -> product reg -> accumulator, 3 cycles of latency
  logic [15:0] op_a, op_b, prod, acc;
  always @(posedge clk or posedge rst) begin
    if (rst || mac_clr) begin
      op_a <= 16'h0; op_b <= 16'h0; prod <= 16'h0; acc <= 16'h0;
    end else if (mac_en) begin
      op_a <= mac_a;
      op_b <= mac_b;
      prod <= 16'(op_a * op_b);
      acc  <= acc + prod;
    end
  end
  assign mac_acc = acc;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] ra [8];
  logic [7:0] rb [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_busy"},   {31'd0, busy},    32'd0);
    chk({tag, "_done"},   {31'd0, done},    32'd0);
    chk({tag, "_result"}, {16'd0, result},  32'd0);
    chk({tag, "_rd_en"},  {31'd0, rd_en},   32'd0);
    chk({tag, "_mac_en"}, {31'd0, mac_en},  32'd0);
    chk({tag, "_mac_clr"},{31'd0, mac_clr}, 32'd0);
    chk({tag, "_ops"},    {mac_a, mac_b},   32'd0);
    chk({tag, "_addr"},   {16'd0, addr_a, addr_b}, 32'd0);
  endtask

  // Launch a job (start sampled at the edge ending cycle 0) and watch it
  // until done or until lim cycles have elapsed.
  task automatic run_job(input logic [8:0] n, input logic [7:0] ba, input logic [7:0] bb,
                         input int ab_c, input int pk_c, input int rs_c, input int lim,
                         output int dcyc, output int rdc, output int enc,
                         output int clrc, output int idlec, output int lclr,
                         output logic [15:0] res);
    dcyc = 0; rdc = 0; enc = 0; clrc = 0; idlec = 0; lclr = 0; res = 16'h0;
    len = n; base_a = ba; base_b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; len = 9'd0; base_a = 8'hAA; base_b = 8'hAA;
    for (int c = 1; c <= lim; c++) begin
      if (rd_en) begin
        if (rdc < 8) begin ra[rdc] = addr_a; rb[rdc] = addr_b; end
        rdc++;
      end
      if (mac_en) enc++;
      if (mac_clr) begin clrc++; lclr = c; end
      if (!busy && idlec == 0) idlec = c;
      if (done) begin dcyc = c; res = result; break; end
      if (c == rs_c) begin
        #2 rst = 1'b1;
        #1 reset_chk("midrst");
        #1 rst = 1'b0;
      end
      abort = (c == ab_c);
      start = (c == pk_c);
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0;
  endtask

  int dc, rc, ec, cc, ic, lc, nd;
  logic [15:0] r;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; len = 9'd0; base_a = 8'd0; base_b = 8'd0;
    for (int i = 0; i < 256; i++) begin mem_a[i] = 16'h0; mem_b[i] = 16'h0; end
    mem_a[0] = 16'd1; mem_a[1] = 16'd2; mem_a[2] = 16'd3; mem_a[3] = 16'd4;
    mem_b[0] = 16'd5; mem_b[1] = 16'd6; mem_b[2] = 16'd7; mem_b[3] = 16'd8;
    mem_a[8'hFE] = 16'd10; mem_a[8'hFF] = 16'd20;
    mem_b[8'h10] = 16'd1;  mem_b[8'h11] = 16'd2; mem_b[8'h12] = 16'd3;
    mem_a[8'h20] = 16'h0100; mem_a[8'h21] = 16'h0100;
    mem_b[8'h20] = 16'h0100; mem_b[8'h21] = 16'h0100;
    for (int i = 0; i < 8; i++) begin mem_a[8'h40 + i] = 16'd9; mem_b[8'h40 + i] = 16'd9; end
    mem_a[8'h30] = 16'd3; mem_b[8'h30] = 16'd4;
    mem_a[8'h50] = 16'd7; mem_a[8'h51] = 16'd9;
    mem_b[8'h50] = 16'd11; mem_b[8'h51] = 16'd13;
    #3 reset_chk("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // basic: 1*5+2*6+3*7+4*8 = 70, done in cycle 10
    run_job(9'd4, 8'h00, 8'h00, 0, 0, 0, 30, dc, rc, ec, cc, ic, lc, r);
    chk("basic_done_cyc", dc, 32'd10);
    chk("basic_result", {16'd0, r}, 32'd70);
    chk("basic_rd_cycles", rc, 32'd4);
    chk("basic_en_cycles", ec, 32'd6);
    chk("basic_clr_pulses", cc, 32'd1);
    @(posedge clk); #1;
    chk("basic_done_pulse", {31'd0, done}, 32'd0);
    chk("basic_result_held", {16'd0, result}, 32'd70);

    // address wrap: 10*1 + 20*2 + 1*3 = 53
    run_job(9'd3, 8'hFE, 8'h10, 0, 0, 0, 30, dc, rc, ec, cc, ic, lc, r);
    chk("wrap_done_cyc", dc, 32'd9);
    chk("wrap_result", {16'd0, r}, 32'd53);
    chk("wrap_rd_cycles", rc, 32'd3);
    chk("wrap_addr_a", {8'd0, ra[0], ra[1], ra[2]}, 32'h00FEFF00);
    chk("wrap_addr_b", {8'd0, rb[0], rb[1], rb[2]}, 32'h00101112);

    // zero length
    run_job(9'd0, 8'h00, 8'h00, 0, 0, 0, 30, dc, rc, ec, cc, ic, lc, r);
    chk("len0_done_cyc", dc, 32'd3);
    chk("len0_result", {16'd0, r}, 32'd0);
    chk("len0_rd_cycles", rc, 32'd0);

    // overflow: 2 * 0x100*0x100 wraps to 0
    run_job(9'd2, 8'h20, 8'h20, 0, 0, 0, 30, dc, rc, ec, cc, ic, lc, r);
    chk("ovf_done_cyc", dc, 32'd8);
    chk("ovf_result", {16'd0, r}, 32'h0);

    // abort in FETCH cycle 4 of a len=8 job
    run_job(9'd8, 8'h40, 8'h40, 4, 0, 0, 25, dc, rc, ec, cc, ic, lc, r);
    chk("abort_no_done", dc, 32'd0);
    chk("abort_idle_cyc", ic, 32'd5);
    chk("abort_clr_pulses", cc, 32'd2);
    chk("abort_clr_cyc", lc, 32'd5);
    chk("abort_result_kept", {16'd0, result}, 32'd0);
    run_job(9'd1, 8'h30, 8'h30, 0, 0, 0, 30, dc, rc, ec, cc, ic, lc, r);
    chk("post_abort_done_cyc", dc, 32'd7);
    chk("post_abort_result", {16'd0, r}, 32'd12);

    // start while busy is ignored, only one done
    run_job(9'd4, 8'h00, 8'h00, 0, 5, 0, 30, dc, rc, ec, cc, ic, lc, r);
    chk("busy_start_done_cyc", dc, 32'd10);
    chk("busy_start_result", {16'd0, r}, 32'd70);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("busy_start_no_second", nd, 32'd0);

    // back-to-back: second start in the done cycle of the first
    run_job(9'd1, 8'h30, 8'h30, 0, 0, 0, 30, dc, rc, ec, cc, ic, lc, r);
    chk("b2b_first_result", {16'd0, r}, 32'd12);
    run_job(9'd2, 8'h50, 8'h50, 0, 0, 0, 30, dc, rc, ec, cc, ic, lc, r);
    chk("b2b_second_done_cyc", dc, 32'd8);
    chk("b2b_second_result", {16'd0, r}, 32'd194);

    // async reset during DRAIN (cycle 7 of a len=4 job)
    run_job(9'd4, 8'h00, 8'h00, 0, 0, 7, 20, dc, rc, ec, cc, ic, lc, r);
    chk("rst_no_done", dc, 32'd0);
    run_job(9'd1, 8'h30, 8'h30, 0, 0, 0, 30, dc, rc, ec, cc, ic, lc, r);
    chk("post_rst_done_cyc", dc, 32'd7);
    chk("post_rst_result", {16'd0, r}, 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Sequencer that computes a 16-bit dot product of two operand vectors using a single external MAC unit. On `start` it clears the MAC, streams `len` operand pairs from two synchronous-read operand memories into the MAC, drains the MAC pipeline, and returns the accumulated value with a one-cycle `done` pulse. It sits between the host control logic and the MAC datapath, owning the MAC's clear, enable and operand inputs.

## Interface
- `AW`, default 8: operand memory address width.
- `MAC_LAT`, default 3: cycles from an operand pair entering the MAC until it is reflected on `mac_acc`. This covers the MAC's operand register, product register and accumulator register stages.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a dot product; sampled only in IDLE.
- `abort` in 1: cancel the operation in progress.
- `len` in AW+1: number of operand pairs, 0..2^AW.
- `base_a`, `base_b` in AW each: start addresses of the two operand vectors.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; `result` is valid in the same cycle.
- `result` out 16: final accumulator value, held until the next `done`.
- `rd_en` out 1: read strobe to both operand memories.
- `addr_a`, `addr_b` out AW each: read addresses.
- `rdata_a`, `rdata_b` in 16 each: read data, valid exactly one cycle after `rd_en`.
- `mac_clr` out 1: registered clear pulse, connected to the MAC reset.
- `mac_en` out 1: MAC enable.
- `mac_a`, `mac_b` out 16 each: MAC operands.
- `mac_acc` in 16: MAC accumulator output.

## Operation
- **FSM states:** IDLE, CLEAR, FETCH, DRAIN, CAPTURE.
- **IDLE:** `start=1` latches `len`, `base_a` and `base_b`, then goes to CLEAR.
- **CLEAR** (1 cycle): `mac_clr=1`. Goes to FETCH if `len!=0`, otherwise to CAPTURE.
- **FETCH** (`len` cycles, index i=0..len-1):
  - `rd_en=1`, `addr_a=base_a+i`, `addr_b=base_b+i`.
  - Addresses wrap modulo 2^AW.
  - Goes to DRAIN after i=len-1.
- **DRAIN** (MAC_LAT cycles): a down-counter, then goes to CAPTURE.
- **CAPTURE** (1 cycle): registers `result<=mac_acc` and `done<=1`, then goes to IDLE.
- **`mac_en`:** 1 in FETCH, in DRAIN, and in the cycle after the last FETCH. It is 0 in IDLE, CLEAR and CAPTURE.
- **Operand gating:**
  - `mac_a`/`mac_b` = `rdata_a`/`rdata_b` in the cycle after a cycle with `rd_en=1`; otherwise 16'h0000.
  - A registered data-valid flag (`rd_en` delayed 1 cycle) does the gating.
  - As a result, zeros flush the MAC pipeline during DRAIN.
- **Arithmetic:** the accumulation is modulo 2^16, with no saturation in this block. `result` carries `mac_acc` unmodified.
- **`start` while busy:** ignored, with no queuing.
- **`abort` in any non-IDLE state:**
  - Next state is IDLE.
  - `mac_clr` pulses for one cycle.
  - `mac_en`, `rd_en` and the data-valid flag are forced to 0.
  - No `done` pulse; `result` is unchanged.
- **`abort` and `start` in IDLE in the same cycle:** `abort` wins; `start` is dropped.
- **`abort` in CAPTURE:** `abort` wins; no `done`.
- **Reset values:** state IDLE, `busy=0`, `done=0`, `result=0`, `rd_en=0`, addresses 0, `mac_clr=0`, `mac_en=0`, `mac_a`=`mac_b`=0, counters 0.
- **Reset mid-operation:** returns to IDLE immediately with no `done`. The MAC is cleared by the system `rst`.

## Timing
- **Cycle numbering:** the `start` sampled edge ends cycle 0.
- **Sequence for len=N≥1:**
  - Cycle 1: CLEAR.
  - Cycles 2..N+1: FETCH.
  - Cycles 3..N+2: `mac_a`/`mac_b` carry data.
  - Cycles 3..N+1+MAC_LAT: `mac_en=1`.
  - Cycles N+2..N+1+MAC_LAT: DRAIN.
  - Cycle N+2+MAC_LAT: CAPTURE.
  - Cycle N+3+MAC_LAT: `done=1`, `busy=0`.
- **Latency:** `start` to `done` is N+3+MAC_LAT cycles; that is N+6 for the default MAC_LAT.
- **len=0:** CLEAR in cycle 1, CAPTURE in cycle 2, `done` with `result=0` in cycle 3.
- **Back-to-back:** a new `start` is accepted in the same cycle `done` is high.
- **Abort timing:** `mac_clr` is high in the cycle after `abort` is sampled, and `busy` goes to 0 in that same cycle.

## Test plan
- **Basic, len=4:** A=[1,2,3,4], B=[5,6,7,8], base 0 → `done` in cycle 10, `result=70`, exactly 4 `rd_en` cycles.
- **Address wrap:** len=3, base_a=8'hFE, base_b=8'h10 → addr_a sequence FE, FF, 00; addr_b sequence 10, 11, 12. `result` matches the model.
- **Zero length and overflow:**
  - len=0 → `done` in cycle 3, `result=0`, no `rd_en`.
  - len=2 with A=B=[16'h0100,16'h0100] → `result=16'h0000`, showing 2^16 wrap.
- **Abort:** abort in FETCH cycle 4 of len=8 → no `done`, `busy` low the next cycle, one `mac_clr` pulse. A following len=1 run with A=3, B=4 gives `result=12`, with no stale accumulation.
- **Busy start and back-to-back:**
  - `start` pulsed in cycle 5 of a running job → ignored, only one `done`.
  - A new `start` in the `done` cycle → second job completes with the correct independent result.
- **Async reset:** `rst` in DRAIN → all outputs return to reset values immediately, no `done`. The next job runs normally.
